// File: rtl/scsi_xfer_pkg.sv
// Shared types and default sizing for the SCSI transfer sequencer.
// The sequencer walks one bus cycle at a time for either a CPU access or a DMA byte.
package scsi_xfer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CPU_SETUP,
      CPU_STROBE,
      CPU_HOLD,
      CPU_WAIT,
      DMA_SETUP,
      DMA_STROBE,
      DMA_HOLD
   } xfer_state_t;

   localparam int LANES_DEF     = 4;
   localparam int RE_WAIT_DEF   = 2;
   localparam int WE_WAIT_DEF   = 2;
   localparam int BURST_MAX_DEF = 4;

   // Wide enough for the longest strobe (15 cycles) and the largest burst (16 bytes).
   localparam int TIMER_W = 4;
   localparam int BURST_W = 5;

endpackage

// File: rtl/scsi_strobe_timer.sv
// Strobe-width down-counter: load at the start of a strobe, count while strobing,
// done when the count reaches zero (that cycle is the last strobe cycle).
module scsi_strobe_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         count,
   output logic         done
);

   logic [W-1:0] cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (count && (cnt_reg != '0)) begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   assign done = (cnt_reg == '0);

endmodule

// File: rtl/scsi_xfer_seq.sv
// SCSI chip bus-cycle sequencer: CPU accesses and byte-wide DMA between the chip and a
// longword FIFO. Define SCSI_XFER_FLUSH_EN to add the FLUSH input for partial longwords.
module scsi_xfer_seq
   import scsi_xfer_pkg::*;
#(
   parameter int LANES     = LANES_DEF,
   parameter int RE_WAIT   = RE_WAIT_DEF,
   parameter int WE_WAIT   = WE_WAIT_DEF,
   parameter int BURST_MAX = BURST_MAX_DEF,
   localparam int BOW      = $clog2(LANES)
) (
   input  logic           CPUCLK,
   input  logic           RESET,
   input  logic           CPUREQ,
   input  logic           RW,
   input  logic           nAS_,
   input  logic           DMADIR,
   input  logic           DREQ_,
   input  logic           FIFOFULL,
   input  logic           FIFOEMPTY,
`ifdef SCSI_XFER_FLUSH_EN
   input  logic           FLUSH,
`endif
   output logic           SCSI_CS_o,
   output logic           RE_o,
   output logic           WE_o,
   output logic           DACK_o,
   output logic           S2CPU_o,
   output logic           CPU2S_o,
   output logic           S2F_o,
   output logic           F2S_o,
   output logic           LS2CPU,
   output logic           INCNI_o,
   output logic           INCNO_o,
   output logic [BOW-1:0] BO_o,
   output logic           CPUACK_o,
   output logic           BUSY_o
);

   localparam logic [TIMER_W-1:0] RE_LD     = TIMER_W'(RE_WAIT - 1);
   localparam logic [TIMER_W-1:0] WE_LD     = TIMER_W'(WE_WAIT - 1);
   localparam logic [BOW-1:0]     BO_LAST   = BOW'(LANES - 1);
   localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(BURST_MAX);

   xfer_state_t          state_reg, state_next;
   logic [BOW-1:0]       bo_reg, bo_next;
   logic [BURST_W-1:0]   burst_reg, burst_next;
   logic                 rw_reg, rw_next;
   logic                 dir_reg, dir_next;

   logic                 tmr_load, tmr_count, tmr_done;
   logic [TIMER_W-1:0]   tmr_load_val;

   logic [BOW-1:0]       bo_inc;
   logic                 fifo_ok, cpu_start, dma_start, dma_cont, flush_hit, bo_wrap;

   // FIFO flags only matter when the next byte opens a fresh longword.
   assign bo_inc    = bo_reg + 1'b1;
   assign fifo_ok   = DMADIR ? !FIFOEMPTY : !FIFOFULL;
   assign cpu_start = CPUREQ && !nAS_;
   assign dma_start = !DREQ_ && !CPUREQ && ((bo_reg != '0) || fifo_ok);
   assign dma_cont  = !DREQ_ && !CPUREQ && ((bo_inc != '0) || fifo_ok) && (burst_reg < BURST_LIM);
   assign bo_wrap   = (bo_reg == BO_LAST);

`ifdef SCSI_XFER_FLUSH_EN
   assign flush_hit = (state_reg == IDLE) && FLUSH && (bo_reg != '0) && !DMADIR;
`else
   assign flush_hit = 1'b0;
`endif

   assign tmr_load  = (state_reg == CPU_SETUP) || (state_reg == DMA_SETUP);
   assign tmr_count = (state_reg == CPU_STROBE) || (state_reg == DMA_STROBE);

   always_comb begin
      tmr_load_val = '0;
      if (state_reg == CPU_SETUP) begin
         tmr_load_val = rw_reg ? RE_LD : WE_LD;
      end else begin
         tmr_load_val = dir_reg ? WE_LD : RE_LD;
      end
   end

   scsi_strobe_timer #(.W(TIMER_W)) u_timer (
      .clk      (CPUCLK),
      .rst      (RESET),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .count    (tmr_count),
      .done     (tmr_done)
   );

   always_ff @(posedge CPUCLK or posedge RESET) begin
      if (RESET) begin
         state_reg <= IDLE;
         bo_reg    <= '0;
         burst_reg <= '0;
         rw_reg    <= 1'b0;
         dir_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         bo_reg    <= bo_next;
         burst_reg <= burst_next;
         rw_reg    <= rw_next;
         dir_reg   <= dir_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      bo_next    = bo_reg;
      burst_next = burst_reg;
      rw_next    = rw_reg;
      dir_next   = dir_reg;
      case (state_reg)
         IDLE: begin
            burst_next = '0;
            if (cpu_start) begin
               state_next = CPU_SETUP;
               rw_next    = RW;
            end else if (flush_hit) begin
               bo_next = '0;
            end else if (dma_start) begin
               state_next = DMA_SETUP;
               dir_next   = DMADIR;
               burst_next = BURST_W'(1);
            end
         end
         CPU_SETUP:  state_next = CPU_STROBE;
         CPU_STROBE: if (tmr_done) state_next = CPU_HOLD;
         CPU_HOLD:   state_next = CPU_WAIT;
         CPU_WAIT:   if (!CPUREQ || nAS_) state_next = IDLE;
         DMA_SETUP:  state_next = DMA_STROBE;
         DMA_STROBE: if (tmr_done) state_next = DMA_HOLD;
         DMA_HOLD: begin
            bo_next = bo_inc;
            if (dma_cont) begin
               state_next = DMA_SETUP;
               dir_next   = DMADIR;
               burst_next = burst_reg + 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs decode straight from registered state so reset clears them at once.
   always_comb begin
      SCSI_CS_o = 1'b0;
      RE_o      = 1'b0;
      WE_o      = 1'b0;
      DACK_o    = 1'b0;
      S2CPU_o   = 1'b0;
      CPU2S_o   = 1'b0;
      S2F_o     = 1'b0;
      F2S_o     = 1'b0;
      LS2CPU    = 1'b0;
      INCNI_o   = 1'b0;
      INCNO_o   = 1'b0;
      CPUACK_o  = 1'b0;
      case (state_reg)
         IDLE: INCNI_o = flush_hit;
         CPU_SETUP, CPU_STROBE, CPU_HOLD: begin
            SCSI_CS_o = 1'b1;
            S2CPU_o   = rw_reg;
            CPU2S_o   = !rw_reg;
            if (state_reg == CPU_STROBE) begin
               RE_o   = rw_reg;
               WE_o   = !rw_reg;
               LS2CPU = rw_reg && tmr_done;
            end
            CPUACK_o = (state_reg == CPU_HOLD);
         end
         DMA_SETUP, DMA_STROBE, DMA_HOLD: begin
            DACK_o = 1'b1;
            S2F_o  = !dir_reg;
            F2S_o  = dir_reg;
            if (state_reg == DMA_STROBE) begin
               RE_o = !dir_reg;
               WE_o = dir_reg;
            end
            if (state_reg == DMA_HOLD) begin
               INCNI_o = bo_wrap && !dir_reg;
               INCNO_o = bo_wrap && dir_reg;
            end
         end
         default: ;
      endcase
   end

   assign BO_o   = bo_reg;
   assign BUSY_o = (state_reg != IDLE);

endmodule

// File: doc/scsi_xfer_seq.md
SCSI_XFER_SEQ -- requirements
Module: scsi_xfer_seq

Interface
REQ-001 SHALL have parameter LANES, 4, bytes per FIFO longword (power of 2, 2..8); BOW = log2(LANES).
REQ-002 SHALL have parameter RE_WAIT, 2, RE_o strobe width in cycles (1..15).
REQ-003 SHALL have parameter WE_WAIT, 2, WE_o strobe width in cycles (1..15).
REQ-004 SHALL have parameter BURST_MAX, 4, max DMA bytes per arbitration (1..16).
REQ-005 SHALL have ports, clock and reset first, and SHALL use one clock; reset is asynchronous and active-high:
- CPUCLK in 1 clock
- RESET in 1 async active-high reset
- CPUREQ in 1 CPU access to SCSI chip
- RW in 1 1 = CPU read
- nAS_ in 1 CPU address strobe, active low
- DMADIR in 1 0 = SCSI->FIFO, 1 = FIFO->SCSI
- DREQ_ in 1 SCSI DMA request, active low
- FIFOFULL in 1 no free longword slot
- FIFOEMPTY in 1 no longword available
- SCSI_CS_o out 1 chip select
- RE_o / WE_o out 1 read/write strobes
- DACK_o out 1 DMA acknowledge
- S2CPU_o / CPU2S_o out 1 CPU data path enables
- S2F_o / F2S_o out 1 FIFO data path enables
- LS2CPU out 1 latch SCSI data for CPU
- INCNI_o / INCNO_o out 1 FIFO write/read pointer increment pulse
- BO_o out BOW byte offset within longword
- CPUACK_o out 1 CPU cycle complete pulse
- BUSY_o out 1 state != IDLE

Function
REQ-006 SHALL implement states IDLE, CPU_SETUP, CPU_STROBE, CPU_HOLD, CPU_WAIT, DMA_SETUP, DMA_STROBE, DMA_HOLD.
REQ-007 From IDLE, CPUREQ=1 and nAS_=0 SHALL go to CPU_SETUP; CPU request SHALL win over simultaneous DMA request.
REQ-008 DMA start SHALL require DREQ_=0, CPUREQ=0 and, only when BO_o=0, FIFOFULL=0 (DMADIR=0) or FIFOEMPTY=0 (DMADIR=1); mid-longword bytes SHALL ignore FIFO flags.
REQ-009 Every bus cycle SHALL be 1 SETUP cycle (CS only), RE_WAIT/WE_WAIT STROBE cycles, 1 HOLD cycle (CS, strobe low); 4 cycles at defaults.
REQ-010 SCSI_CS_o SHALL be 1 in SETUP, STROBE and HOLD; DACK_o SHALL replace SCSI_CS_o during DMA states.
REQ-011 CPU read: S2CPU_o high for the whole cycle, RE_o in STROBE, LS2CPU one pulse on last STROBE cycle; CPU write: CPU2S_o high, WE_o in STROBE.
REQ-012 CPUACK_o SHALL pulse once in CPU_HOLD; CPU_WAIT SHALL hold until CPUREQ=0 or nAS_=1, then IDLE.
REQ-013 DMADIR=0 SHALL use RE_o and S2F_o; DMADIR=1 SHALL use WE_o and F2S_o.
REQ-014 BO_o SHALL increment modulo LANES in each DMA_HOLD; on wrap LANES-1->0 SHALL pulse INCNI_o (DMADIR=0) or INCNO_o (DMADIR=1) for exactly one cycle.
REQ-015 From DMA_HOLD SHALL go to DMA_SETUP if REQ-008 holds and burst count < BURST_MAX, else IDLE; burst count SHALL clear in IDLE.
REQ-016 DREQ_, CPUREQ or DMADIR changes mid-cycle SHALL NOT abort the cycle in progress; BO_o SHALL persist across CPU cycles.

Reset
REQ-017 RESET=1 SHALL immediately force IDLE, all outputs 0, BO_o=0, burst count 0, independent of CPUCLK.

Configuration
REQ-018 With SCSI_XFER_FLUSH_EN defined SHALL add input FLUSH: in IDLE with BO_o!=0 and DMADIR=0, pulse INCNI_o once and clear BO_o; FLUSH ignored otherwise.
REQ-019 Without SCSI_XFER_FLUSH_EN the FLUSH port SHALL be absent and BO_o cleared only by reset or wrap.

Structure
REQ-020 Package scsi_xfer_pkg SHALL hold the state enum and default parameter constants.
REQ-021 Strobe down-counter SHALL be sub-module scsi_strobe_timer (load, count, done).

Verification (LANES=4, RE_WAIT=2, WE_WAIT=2, BURST_MAX=4)
REQ-022 RESET high 2 cycles -> all outputs 0, BO_o=0, BUSY_o=0.
REQ-023 CPUREQ=1, RW=1, nAS_=0 -> CS 4 cycles, RE_o cycles 2-3, LS2CPU cycle 3, CPUACK_o cycle 4, no retrigger until CPUREQ=0.
REQ-024 DMADIR=0, DREQ_ held 0, FIFOFULL=0 -> 4 bytes back-to-back (16 cycles), BO_o 1,2,3,0, one INCNI_o at wrap, IDLE 1 cycle, burst restarts.
REQ-025 CPUREQ=1 during byte 2 of burst -> byte completes, CPU cycle runs, DMA resumes at BO_o=2.
REQ-026 DMADIR=1, FIFOEMPTY=1, DREQ_=0 -> no DACK_o; FIFOEMPTY=0 -> WE_o cycles, INCNO_o after byte 4.
REQ-027 RESET during DMA_STROBE at BO_o=2 -> RE_o, DACK_o 0 same cycle, BO_o=0; with SCSI_XFER_FLUSH_EN, FLUSH at BO_o=3 -> INCNI_o pulse, BO_o=0.
